pattern_detector_param: RTL and testbench
=========================================

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 SHALL: Parameter PAT_W, default 5, pattern length in bits, legal range 2..16.
REQ-002 SHALL: Parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL: Parameter PAT_RST, default 5'b11001 (sized PAT_W), pattern loaded at reset.
REQ-004 SHALL: Port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL: Port rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 SHALL: Port d_in  input  1  serial data bit.
REQ-007 SHALL: Port valid_in  input  1  d_in is sampled only when 1.
REQ-008 SHALL: Port pat_load  input  1  load pat_in as the new pattern.
REQ-009 SHALL: Port pat_in  input  PAT_W  new pattern; pat_in[PAT_W-1] is the first bit in time.
REQ-010 SHALL: Port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL: Port cnt_clr  input  1  synchronous clear of match_count.
REQ-012 SHALL: Port pattern_detected  output  1  one-cycle registered detection pulse.
REQ-013 SHALL: Port match_level  output  $clog2(PAT_W+1)  current matched-prefix length.
REQ-014 SHALL: Port match_count  output  CNT_W  saturating count of detections.

Function
REQ-015 SHALL: Hold state k = matched-prefix length, 0..PAT_W-1, plus a PAT_W-bit history of accepted bits; match_level = k.
REQ-016 SHALL: On an accepted bit (valid_in=1, pat_load=0), set j = largest value <= k+1 such that the last j accepted bits equal pat[PAT_W-1 : PAT_W-j]; j=0 if none.
REQ-017 SHALL: If j < PAT_W, set k = j next cycle, with pattern_detected = 0.
REQ-018 SHALL: If j = PAT_W, assert pattern_detected for exactly the following cycle and increment match_count.
REQ-019 SHALL: On a full match with overlap_en=1, set k = longest proper border of pat (longest prefix that is also a suffix, < PAT_W), history retained.
REQ-020 SHALL: On a full match with overlap_en=0, set k = 0 and clear history, so no bit of the matched window is reused.
REQ-021 SHALL: Latency is one cycle: pattern_detected is high in the cycle after the cycle the final pattern bit was accepted.
REQ-022 SHALL: When valid_in=0, hold k, history and pattern, and drive pattern_detected = 0 next cycle; gaps of any length are transparent.
REQ-023 SHALL: On pat_load=1, latch pat_in, clear k and history next cycle; d_in is discarded that cycle; match_count is unaffected.
REQ-024 SHALL: Sample overlap_en per accepted bit; a change takes effect on the next full match.
REQ-025 SHALL: Saturate match_count at 2^CNT_W-1 with no wrap.
REQ-026 SHALL: On cnt_clr=1, set match_count = 0 next cycle; a simultaneous detection is dropped from the count, though pattern_detected still pulses.
REQ-027 SHALL: Implement the prefix search as combinational compares of all prefix lengths (priority longest-first); no multi-cycle search.

Reset
REQ-028 SHALL: When rst=0, asynchronously set pattern_detected=0, match_level=0, match_count=0, history=0, pattern=PAT_RST.
REQ-029 SHALL: Reset asserted mid-sequence discards any partial match; the first accepted bit after release starts from k=0.
REQ-030 SHALL: Accept no input in the first rising edge where rst is still 0; release is synchronous to clk externally.

Verification
REQ-031 SHALL: Reset, pattern 11001, stream 1,1,0,0,1 valid every cycle -> one pulse the cycle after the 5th bit, match_count=1, match_level=0 (border of 11001 is "1", so overlap gives match_level=1).
REQ-032 SHALL: pat_load 10101, overlap_en=1, stream 1,0,1,0,1,0,1 -> pulses after bits 5 and 7, match_count=2, match_level=3 at end.
REQ-033 SHALL: Same as REQ-032 with overlap_en=0 -> single pulse after bit 5, match_count=1, match_level=1 at end.
REQ-034 SHALL: Pattern 11001, bits 1,1,0 then valid_in=0 for 4 cycles, then 0,1 -> single pulse after last bit; no pulse during gap.
REQ-035 SHALL: Pattern 11001, bits 1,1,0, rst pulsed low, then 0,1 -> no pulse, match_level=1 at end, match_count=0.
REQ-036 SHALL: CNT_W=2, six full matches -> match_count stops at 3; cnt_clr with a coincident match -> match_count=0, pulse still seen.

Source files
------------

// File: rtl/pattern_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, optional overlapping
// detection and a saturating match counter.
module pattern_detector_param #(
   parameter int              PAT_W   = 5,
   parameter int              CNT_W   = 8,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(5'b11001)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       d_in,
   input  logic                       valid_in,
   input  logic                       pat_load,
   input  logic [PAT_W-1:0]           pat_in,
   input  logic                       overlap_en,
   input  logic                       cnt_clr,
   output logic                       pattern_detected,
   output logic [$clog2(PAT_W+1)-1:0] match_level,
   output logic [CNT_W-1:0]           match_count
);

   localparam int LW = $clog2(PAT_W + 1);

   logic [PAT_W-1:0] pat;
   // The newest bit always comes straight from d_in, so PAT_W-1 stored bits
   // complete the longest window that ever has to be compared.
   logic [PAT_W-2:0] history;
   logic [PAT_W-1:0] hist_shift;
   logic [PAT_W-1:0] mask;
   logic             accept;
   logic             full_match;
   int               j_val;
   int               border_val;

   always_comb begin
      accept     = valid_in & ~pat_load;
      hist_shift = {history, d_in};
      mask       = '0;
      j_val      = 0;
      border_val = 0;
      // Longest matched prefix ending at the new bit; later hits override earlier.
      for (int j = 1; j <= PAT_W; j++) begin
         mask = {PAT_W{1'b1}} >> (PAT_W - j);
         if ((j <= int'(match_level) + 1) &&
             ((hist_shift & mask) == ((pat >> (PAT_W - j)) & mask)))
            j_val = j;
      end
      // Longest proper border of the current pattern, used to resume after a hit.
      for (int b = 1; b < PAT_W; b++) begin
         mask = {PAT_W{1'b1}} >> (PAT_W - b);
         if (((pat >> (PAT_W - b)) & mask) == (pat & mask))
            border_val = b;
      end
      full_match = accept && (j_val == PAT_W);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat              <= PAT_RST;
         history          <= '0;
         match_level      <= '0;
         pattern_detected <= 1'b0;
      end else if (pat_load) begin
         pat              <= pat_in;
         history          <= '0;
         match_level      <= '0;
         pattern_detected <= 1'b0;
      end else if (valid_in) begin
         pattern_detected <= full_match;
         if (full_match && !overlap_en) begin
            history     <= '0;
            match_level <= '0;
         end else if (full_match) begin
            history     <= hist_shift[PAT_W-2:0];
            match_level <= LW'(border_val);
         end else begin
            history     <= hist_shift[PAT_W-2:0];
            match_level <= LW'(j_val);
         end
      end else begin
         pattern_detected <= 1'b0;
      end
   end

   // A clear wins over a coincident detection; the count never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         match_count <= '0;
      else if (cnt_clr)
         match_count <= '0;
      else if (full_match && (match_count != {CNT_W{1'b1}}))
         match_count <= match_count + 1'b1;
   end

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench for pattern_detector_param: a default instance plus a
// 2-bit-counter instance driven by the same stimulus.
module tb_pattern_detector_param;

   logic       clk;
   logic       rst;
   logic       d_in;
   logic       valid_in;
   logic       pat_load;
   logic [4:0] pat_in;
   logic       overlap_en;
   logic       cnt_clr;

   logic       det;
   logic [2:0] level;
   logic [7:0] count;
   logic       det2;
   logic [2:0] level2;
   logic [1:0] count2;

   int checks = 0;
   int errors = 0;

   pattern_detector_param dut (
      .clk(clk), .rst(rst), .d_in(d_in), .valid_in(valid_in),
      .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
      .cnt_clr(cnt_clr), .pattern_detected(det), .match_level(level),
      .match_count(count)
   );

   pattern_detector_param #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .d_in(d_in), .valid_in(valid_in),
      .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
      .cnt_clr(cnt_clr), .pattern_detected(det2), .match_level(level2),
      .match_count(count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic b, input logic exp_det, input string tag);
      valid_in = 1'b1;
      d_in     = b;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      d_in     = 1'b0;
      check_output(tag, 32'(det), 32'(exp_det));
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clk);
      #1;
      check_output(tag, 32'(det), 32'd0);
   endtask

   task automatic load_pattern(input logic [4:0] p);
      pat_load = 1'b1;
      pat_in   = p;
      valid_in = 1'b1;
      d_in     = 1'b1;
      @(posedge clk);
      #1;
      pat_load = 1'b0;
      valid_in = 1'b0;
      d_in     = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      d_in       = 1'b0;
      valid_in   = 1'b0;
      pat_load   = 1'b0;
      pat_in     = 5'b00000;
      overlap_en = 1'b0;
      cnt_clr    = 1'b0;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check_output("reset_det", 32'(det), 32'd0);
      check_output("reset_level", 32'(level), 32'd0);
      check_output("reset_count", 32'(count), 32'd0);
      check_output("reset_count2", 32'(count2), 32'd0);
      rst = 1'b1;

      // Default pattern 11001, non-overlapping
      apply_stimulus(1'b1, 1'b0, "p1_b1");
      apply_stimulus(1'b1, 1'b0, "p1_b2");
      apply_stimulus(1'b0, 1'b0, "p1_b3");
      check_output("p1_level3", 32'(level), 32'd3);
      apply_stimulus(1'b0, 1'b0, "p1_b4");
      apply_stimulus(1'b1, 1'b1, "p1_b5");
      check_output("p1_count", 32'(count), 32'd1);
      check_output("p1_level", 32'(level), 32'd0);
      idle_cycle("p1_pulse_one_cycle");

      // Same pattern, overlapping: border "1" is reused
      overlap_en = 1'b1;
      apply_stimulus(1'b1, 1'b0, "p2_b1");
      apply_stimulus(1'b1, 1'b0, "p2_b2");
      apply_stimulus(1'b0, 1'b0, "p2_b3");
      apply_stimulus(1'b0, 1'b0, "p2_b4");
      apply_stimulus(1'b1, 1'b1, "p2_b5");
      check_output("p2_level", 32'(level), 32'd1);
      check_output("p2_count", 32'(count), 32'd2);
      apply_stimulus(1'b1, 1'b0, "p2_b6");
      apply_stimulus(1'b0, 1'b0, "p2_b7");
      apply_stimulus(1'b0, 1'b0, "p2_b8");
      apply_stimulus(1'b1, 1'b1, "p2_b9");
      check_output("p2_count_b", 32'(count), 32'd3);

      // Load 10101, overlapping
      load_pattern(5'b10101);
      check_output("load_det", 32'(det), 32'd0);
      check_output("load_level", 32'(level), 32'd0);
      check_output("load_count", 32'(count), 32'd3);
      apply_stimulus(1'b1, 1'b0, "p3_b1");
      apply_stimulus(1'b0, 1'b0, "p3_b2");
      apply_stimulus(1'b1, 1'b0, "p3_b3");
      apply_stimulus(1'b0, 1'b0, "p3_b4");
      apply_stimulus(1'b1, 1'b1, "p3_b5");
      apply_stimulus(1'b0, 1'b0, "p3_b6");
      apply_stimulus(1'b1, 1'b1, "p3_b7");
      check_output("p3_level", 32'(level), 32'd3);
      check_output("p3_count", 32'(count), 32'd5);

      // Same pattern, non-overlapping
      overlap_en = 1'b0;
      load_pattern(5'b10101);
      apply_stimulus(1'b1, 1'b0, "p4_b1");
      apply_stimulus(1'b0, 1'b0, "p4_b2");
      apply_stimulus(1'b1, 1'b0, "p4_b3");
      apply_stimulus(1'b0, 1'b0, "p4_b4");
      apply_stimulus(1'b1, 1'b1, "p4_b5");
      apply_stimulus(1'b0, 1'b0, "p4_b6");
      apply_stimulus(1'b1, 1'b0, "p4_b7");
      check_output("p4_level", 32'(level), 32'd1);
      check_output("p4_count", 32'(count), 32'd6);

      // Valid gap is transparent
      load_pattern(5'b11001);
      apply_stimulus(1'b1, 1'b0, "p5_b1");
      apply_stimulus(1'b1, 1'b0, "p5_b2");
      apply_stimulus(1'b0, 1'b0, "p5_b3");
      for (int i = 0; i < 4; i++) begin
         idle_cycle("p5_gap_det");
         check_output("p5_gap_level", 32'(level), 32'd3);
      end
      apply_stimulus(1'b0, 1'b0, "p5_b4");
      apply_stimulus(1'b1, 1'b1, "p5_b5");
      check_output("p5_count", 32'(count), 32'd7);

      // Reset mid-sequence discards the partial match
      apply_stimulus(1'b1, 1'b0, "p6_b1");
      apply_stimulus(1'b1, 1'b0, "p6_b2");
      apply_stimulus(1'b0, 1'b0, "p6_b3");
      rst = 1'b0;
      #1;
      check_output("p6_async_level", 32'(level), 32'd0);
      check_output("p6_async_count", 32'(count), 32'd0);
      check_output("p6_async_det", 32'(det), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, "p6_b4");
      apply_stimulus(1'b1, 1'b0, "p6_b5");
      check_output("p6_level", 32'(level), 32'd1);
      check_output("p6_count", 32'(count), 32'd0);
      check_output("p6_count2", 32'(count2), 32'd0);

      // Saturation of the 2-bit counter, then clear against a coincident match
      load_pattern(5'b11001);
      for (int n = 1; n <= 6; n++) begin
         apply_stimulus(1'b1, 1'b0, "p7_b1");
         apply_stimulus(1'b1, 1'b0, "p7_b2");
         apply_stimulus(1'b0, 1'b0, "p7_b3");
         apply_stimulus(1'b0, 1'b0, "p7_b4");
         apply_stimulus(1'b1, 1'b1, "p7_b5");
         check_output("p7_count2", 32'(count2), (n > 3) ? 32'd3 : 32'(n));
      end
      check_output("p7_count", 32'(count), 32'd6);
      apply_stimulus(1'b1, 1'b0, "p8_b1");
      apply_stimulus(1'b1, 1'b0, "p8_b2");
      apply_stimulus(1'b0, 1'b0, "p8_b3");
      apply_stimulus(1'b0, 1'b0, "p8_b4");
      cnt_clr = 1'b1;
      apply_stimulus(1'b1, 1'b1, "p8_clr_det");
      cnt_clr = 1'b0;
      check_output("p8_clr_det2", 32'(det2), 32'd1);
      check_output("p8_clr_count", 32'(count), 32'd0);
      check_output("p8_clr_count2", 32'(count2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
